// File: rtl/dense_bin_layer_if.sv
// dense_bin_layer_if: Avalon-MM style SDRAM master bus used by the layer engine.
interface dense_bin_layer_if;
  logic [31:0] avm_address;
  logic        avm_read_n;
  logic        avm_write_n;
  logic        avm_chipselect;
  logic [1:0]  avm_byteenable;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read_n, avm_write_n, avm_chipselect,
           avm_byteenable, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read_n, avm_write_n, avm_chipselect,
           avm_byteenable, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/dense_bin_layer.sv
// dense_bin_layer: binary-input fully-connected layer engine.
// Streams the signed 8-bit kernel from SDRAM into byte-wide BRAM (skipped when
// already resident), then per sample sums the weights of set input bits plus a
// bias, applies sign activation and writes packed 16-bit outputs to SDRAM.
// Optional feature: define ACC_SAT_EN to saturate every accumulator addition
// instead of wrapping.
module dense_bin_layer #(
  parameter int unsigned N_IN      = 360,
  parameter int unsigned N_OUT     = 200,
  parameter int unsigned N_SAMPLES = 100,
  parameter logic [31:0] W_BASE    = 32'h0,
  parameter logic [31:0] X_BASE    = 32'hA000,
  parameter logic [31:0] Y_BASE    = 32'hE000,
  parameter int unsigned ACC_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  dense_bin_layer_if.master        avm,
  input  logic                     start,
  input  logic                     reload,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              samples_done,
  output logic [16:0]              wt_addr,
  output logic [7:0]               wt_wdata,
  output logic                     wt_we,
  input  logic [7:0]               wt_rdata,
  output logic [3:0]               state
);

  localparam int unsigned KW      = (N_OUT * (N_IN + 1) + 1) / 2;
  localparam int unsigned WIN     = (N_IN + 15) / 16;
  localparam int unsigned XW      = WIN * 16;
  localparam int unsigned NSTRIDE = N_IN + 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOADW = 4'd1,
    S_LOADX = 4'd2,
    S_BIAS  = 4'd3,
    S_ACCUM = 4'd4,
    S_ACT   = 4'd5,
    S_WRITE = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t            st;
  logic              wt_valid;
  logic              rd_pend;
  logic              hi_pend;
  logic [7:0]        hi_byte;
  logic [31:0]       wcnt;
  logic [31:0]       x_ptr;
  logic [31:0]       y_ptr;
  logic [XW-1:0]     x_bits;
  logic [XW-1:0]     x_work;
  logic [15:0]       i_cnt;
  logic [15:0]       j_cnt;
  logic [3:0]        jb;
  logic [16:0]       nb;
  logic [ACC_W-1:0]  acc;
  logic [15:0]       out_word;

  logic [7:0]        term_c;
  logic [ACC_W-1:0]  sum_c;
  logic              act_bit_c;
  logic [15:0]       word_c;

  // Sign-extended accumulate; saturates or wraps depending on build option.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0] w);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-7){w[7]}}, w};
`ifdef ACC_SAT_EN
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s[ACC_W-1:0];
  endfunction

  // Weight term gated by the current input bit, next accumulator and output word.
  always_comb begin
    term_c    = x_work[0] ? wt_rdata : 8'd0;
    sum_c     = acc_add(acc, term_c);
    act_bit_c = ~sum_c[ACC_W-1];
    word_c    = out_word;
    word_c[jb] = act_bit_c;
  end

  assign avm.avm_chipselect = 1'b1;
  assign avm.avm_byteenable = 2'b11;
  assign state              = st;

  // Main controller: SDRAM transfers, BRAM kernel fill and node compute.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st                <= S_IDLE;
      wt_valid          <= 1'b0;
      rd_pend           <= 1'b0;
      hi_pend           <= 1'b0;
      hi_byte           <= 8'd0;
      wcnt              <= 32'd0;
      x_ptr             <= 32'd0;
      y_ptr             <= 32'd0;
      x_bits            <= '0;
      x_work            <= '0;
      i_cnt             <= 16'd0;
      j_cnt             <= 16'd0;
      jb                <= 4'd0;
      nb                <= 17'd0;
      acc               <= '0;
      out_word          <= 16'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
      samples_done      <= 16'd0;
      wt_addr           <= 17'd0;
      wt_wdata          <= 8'd0;
      wt_we             <= 1'b0;
      avm.avm_address   <= 32'd0;
      avm.avm_read_n    <= 1'b1;
      avm.avm_write_n   <= 1'b1;
      avm.avm_writedata <= 16'd0;
    end else begin
      wt_we <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            samples_done   <= 16'd0;
            busy           <= 1'b1;
            x_ptr          <= X_BASE;
            y_ptr          <= Y_BASE;
            wcnt           <= 32'd0;
            rd_pend        <= 1'b0;
            hi_pend        <= 1'b0;
            avm.avm_read_n <= 1'b0;
            if (reload || !wt_valid) begin
              st              <= S_LOADW;
              avm.avm_address <= W_BASE;
            end else begin
              st              <= S_LOADX;
              avm.avm_address <= X_BASE;
            end
          end
        end

        S_LOADW: begin
          if (!avm.avm_read_n) begin
            if (!avm.avm_waitrequest) begin
              avm.avm_read_n <= 1'b1;
              rd_pend        <= 1'b1;
            end
          end else if (rd_pend) begin
            if (avm.avm_readdatavalid) begin
              wt_we    <= 1'b1;
              wt_addr  <= 17'(wcnt << 1);
              wt_wdata <= avm.avm_readdata[7:0];
              hi_byte  <= avm.avm_readdata[15:8];
              hi_pend  <= 1'b1;
              rd_pend  <= 1'b0;
              wcnt     <= wcnt + 32'd1;
            end
          end else if (hi_pend) begin
            wt_we          <= 1'b1;
            wt_addr        <= wt_addr + 17'd1;
            wt_wdata       <= hi_byte;
            hi_pend        <= 1'b0;
            avm.avm_read_n <= 1'b0;
            if (wcnt == 32'(KW)) begin
              wt_valid        <= 1'b1;
              wcnt            <= 32'd0;
              avm.avm_address <= x_ptr;
              st              <= S_LOADX;
            end else begin
              avm.avm_address <= W_BASE + wcnt;
            end
          end
        end

        S_LOADX: begin
          if (!avm.avm_read_n) begin
            if (!avm.avm_waitrequest) begin
              avm.avm_read_n <= 1'b1;
              rd_pend        <= 1'b1;
            end
          end else if (rd_pend && avm.avm_readdatavalid) begin
            rd_pend <= 1'b0;
            x_ptr   <= x_ptr + 32'd1;
            x_bits  <= (x_bits >> 16) | (XW'(avm.avm_readdata) << (XW - 16));
            if (wcnt + 32'd1 == 32'(WIN)) begin
              wcnt     <= 32'd0;
              j_cnt    <= 16'd0;
              jb       <= 4'd0;
              nb       <= 17'd0;
              wt_addr  <= 17'd0;
              out_word <= 16'd0;
              st       <= S_BIAS;
            end else begin
              wcnt            <= wcnt + 32'd1;
              avm.avm_read_n  <= 1'b0;
              avm.avm_address <= x_ptr + 32'd1;
            end
          end
        end

        S_BIAS: begin
          x_work  <= x_bits;
          wt_addr <= nb + 17'd1;
          i_cnt   <= 16'd0;
          st      <= S_ACCUM;
        end

        S_ACCUM: begin
          if (i_cnt == 16'd0) begin
            acc <= {{(ACC_W-8){wt_rdata[7]}}, wt_rdata};
          end else begin
            acc    <= sum_c;
            x_work <= x_work >> 1;
          end
          wt_addr <= wt_addr + 17'd1;
          i_cnt   <= i_cnt + 16'd1;
          if (i_cnt == 16'(N_IN - 1))
            st <= S_ACT;
        end

        S_ACT: begin
          out_word <= word_c;
          acc      <= sum_c;
          if (jb == 4'hF || j_cnt == 16'(N_OUT - 1)) begin
            avm.avm_write_n   <= 1'b0;
            avm.avm_address   <= y_ptr;
            avm.avm_writedata <= word_c;
            st                <= S_WRITE;
          end else begin
            j_cnt   <= j_cnt + 16'd1;
            jb      <= jb + 4'd1;
            nb      <= nb + 17'(NSTRIDE);
            wt_addr <= nb + 17'(NSTRIDE);
            st      <= S_BIAS;
          end
        end

        S_WRITE: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write_n <= 1'b1;
            y_ptr           <= y_ptr + 32'd1;
            out_word        <= 16'd0;
            if (j_cnt == 16'(N_OUT - 1)) begin
              st <= S_NEXT;
            end else begin
              j_cnt   <= j_cnt + 16'd1;
              jb      <= jb + 4'd1;
              nb      <= nb + 17'(NSTRIDE);
              wt_addr <= nb + 17'(NSTRIDE);
              st      <= S_BIAS;
            end
          end
        end

        S_NEXT: begin
          samples_done <= samples_done + 16'd1;
          if (samples_done == 16'(N_SAMPLES - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= S_DONE;
          end else begin
            wcnt            <= 32'd0;
            rd_pend         <= 1'b0;
            avm.avm_read_n  <= 1'b0;
            avm.avm_address <= x_ptr;
            st              <= S_LOADX;
          end
        end

        S_DONE: begin
          if (!start) begin
            done <= 1'b0;
            st   <= S_IDLE;
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_bin_layer.sv
// tb_dense_bin_layer: scoreboard bench for dense_bin_layer with a random-stall
// SDRAM model, a 1-cycle BRAM model and a small ACC_W=9 overflow instance.
module tb_dense_bin_layer;

  localparam int unsigned N_IN      = 20;
  localparam int unsigned N_OUT     = 18;
  localparam int unsigned N_SAMPLES = 2;
  localparam int unsigned KW        = (N_OUT * (N_IN + 1) + 1) / 2;
  localparam logic [31:0] XB        = 32'hA000;
  localparam logic [31:0] YB        = 32'hE000;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, reload = 1'b0, start2 = 1'b0, reload2 = 1'b0;
  logic busy, done, busy2, done2;
  logic [15:0] samples_done, samples_done2;
  logic [16:0] wt_addr, wt_addr2;
  logic [7:0]  wt_wdata, wt_wdata2, wt_rdata, wt_rdata2;
  logic        wt_we, wt_we2;
  logic [3:0]  state, state2;

  int total = 0;
  int bad = 0;
  int wreads = 0;
  int lat1 = 0, lat2 = 0;
  logic [15:0] hold1, hold2;
  logic [15:0] kmem [0:KW-1];
  logic [15:0] xmem [0:3];
  logic [7:0]  kb   [0:379];
  logic [7:0]  bram [0:1023];
  logic [7:0]  bram2 [0:7];
  wr_t expq[$];
  wr_t wq[$];

  always #5 clk = ~clk;

  dense_bin_layer_if bus ();
  dense_bin_layer_if bus2 ();

  dense_bin_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .N_SAMPLES(N_SAMPLES)) dut (
    .clk(clk), .reset_n(reset_n), .avm(bus), .start(start), .reload(reload),
    .busy(busy), .done(done), .samples_done(samples_done), .wt_addr(wt_addr),
    .wt_wdata(wt_wdata), .wt_we(wt_we), .wt_rdata(wt_rdata), .state(state)
  );

  dense_bin_layer #(.N_IN(2), .N_OUT(1), .N_SAMPLES(1), .ACC_W(9)) dut2 (
    .clk(clk), .reset_n(reset_n), .avm(bus2), .start(start2), .reload(reload2),
    .busy(busy2), .done(done2), .samples_done(samples_done2), .wt_addr(wt_addr2),
    .wt_wdata(wt_wdata2), .wt_we(wt_we2), .wt_rdata(wt_rdata2), .state(state2)
  );

  // BRAM models: synchronous write, 1-cycle read latency
  always @(posedge clk) begin
    if (wt_we) bram[wt_addr[9:0]] <= wt_wdata;
    wt_rdata <= bram[wt_addr[9:0]];
    if (wt_we2) bram2[wt_addr2[2:0]] <= wt_wdata2;
    wt_rdata2 <= bram2[wt_addr2[2:0]];
  end

  function automatic int bias_f(input int j);
    if (j == 0) return -1;
    if (j == 1) return 0;
    return (j % 5) - 2;
  endfunction

  function automatic int wt_f(input int j, input int i);
    return ((i * 7 + j * 3) % 11) - 5;
  endfunction

  function automatic logic xbit(input int s, input int i);
    logic [15:0] w;
    w = xmem[s * 2 + i / 16];
    return w[i % 16];
  endfunction

  function automatic logic [15:0] model_word(input int s, input int w);
    logic [15:0] r;
    int acc;
    int j;
    r = 16'd0;
    for (int b = 0; b < 16; b++) begin
      j = w * 16 + b;
      if (j < int'(N_OUT)) begin
        acc = bias_f(j);
        for (int i = 0; i < int'(N_IN); i++)
          if (xbit(s, i)) acc = acc + wt_f(j, i);
        r[b] = (acc >= 0);
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] mem1(input logic [31:0] a);
    if (a < 32'(KW)) return kmem[a];
    if (a >= XB && a < XB + 32'd4) return xmem[a - XB];
    return 16'hDEAD;
  endfunction

  function automatic logic [15:0] mem2(input logic [31:0] a);
    if (a == 32'd0) return 16'h7F7F;
    if (a == 32'd1) return 16'h007F;
    if (a == XB) return 16'h0003;
    return 16'hBEEF;
  endfunction

  function automatic wr_t mk(input logic id, input logic [31:0] a, input logic [15:0] d);
    wr_t t;
    t.id = id;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  // SDRAM slave models: decide stalls and return read data at the falling edge
  always @(negedge clk) begin
    bus.avm_readdatavalid  = 1'b0;
    bus2.avm_readdatavalid = 1'b0;
    bus2.avm_waitrequest   = 1'b0;
    if (!reset_n) begin
      lat1 = 0;
      lat2 = 0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = 16'd0;
      bus2.avm_readdata   = 16'd0;
    end else begin
      if (lat1 > 0) begin
        lat1 = lat1 - 1;
        if (lat1 == 0) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = hold1;
        end
      end
      if (lat2 > 0) begin
        lat2 = lat2 - 1;
        if (lat2 == 0) begin
          bus2.avm_readdatavalid = 1'b1;
          bus2.avm_readdata      = hold2;
        end
      end
      bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
      if (!bus.avm_read_n && !bus.avm_waitrequest) begin
        hold1 = mem1(bus.avm_address);
        lat1  = $urandom_range(1, 3);
        if (bus.avm_address < 32'(KW)) wreads = wreads + 1;
      end
      if (!bus.avm_write_n && !bus.avm_waitrequest)
        wq.push_back(mk(1'b0, bus.avm_address, bus.avm_writedata));
      if (!bus2.avm_read_n) begin
        hold2 = mem2(bus2.avm_address);
        lat2  = 1;
      end
      if (!bus2.avm_write_n)
        wq.push_back(mk(1'b1, bus2.avm_address, bus2.avm_writedata));
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop accepted writes and compare against the scoreboard
  task automatic monitor();
    wr_t got, ex;
    forever begin
      @(posedge clk);
      #1;
      while (wq.size() > 0) begin
        got = wq.pop_front();
        if (expq.size() == 0) begin
          total = total + 1;
          bad = bad + 1;
          $display("FAIL unexpected_write: got addr %h data %h, none expected", got.addr, got.data);
        end else begin
          ex = expq.pop_front();
          check("wr_id", 32'(got.id), 32'(ex.id));
          check("wr_addr", got.addr, ex.addr);
          check("wr_data", 32'(got.data), 32'(ex.data));
          if (!got.id && got.addr[0])
            check("word1_pad_zero", 32'(got.data & 16'hFFFC), 32'd0);
        end
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_read_n", 32'(bus.avm_read_n), 32'd1);
    check("rst_write_n", 32'(bus.avm_write_n), 32'd1);
    check("rst_address", bus.avm_address, 32'd0);
    check("rst_writedata", 32'(bus.avm_writedata), 32'd0);
    check("rst_wt_we", 32'(wt_we), 32'd0);
    check("rst_wt_addr", 32'(wt_addr), 32'd0);
    check("rst_wt_wdata", 32'(wt_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_samples_done", 32'(samples_done), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("chipselect", 32'(bus.avm_chipselect), 32'd1);
    check("byteenable", 32'(bus.avm_byteenable), 32'd3);
  endtask

  task automatic push_run();
    expq.push_back(mk(1'b0, YB,          model_word(0, 0)));
    expq.push_back(mk(1'b0, YB + 32'd1,  model_word(0, 1)));
    // sample 1 is all-zero input: outputs are just the bias signs
    expq.push_back(mk(1'b0, YB + 32'd2,  16'h739E));
    expq.push_back(mk(1'b0, YB + 32'd3,  16'h0002));
  endtask

  task automatic wait_done(input string nm);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  task automatic finish_run(input string nm, input int wr_base, input int wr_exp);
    wait_done({nm, "_timeout"});
    check({nm, "_samples_done"}, 32'(samples_done), 32'd2);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_kernel_reads"}, 32'(wreads - wr_base), 32'(wr_exp));
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({nm, "_idle"}, 32'(state), 32'd0);
    check({nm, "_writes_seen"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int base;
    logic hit;
    fork
      monitor();
    join_none

    for (int j = 0; j < int'(N_OUT); j++) begin
      kb[j * 21] = 8'(bias_f(j));
      for (int i = 0; i < int'(N_IN); i++)
        kb[j * 21 + 1 + i] = 8'(wt_f(j, i));
    end
    kb[378] = 8'd0;
    kb[379] = 8'd0;
    for (int k = 0; k < int'(KW); k++)
      kmem[k] = {kb[2 * k + 1], kb[2 * k]};
    xmem[0] = 16'hA5C3;
    xmem[1] = 16'hF009;
    xmem[2] = 16'h0000;
    xmem[3] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;

    // run 1: full kernel load
    push_run();
    base = wreads;
    @(negedge clk);
    reload = 1'b1;
    start = 1'b1;
    finish_run("run1", base, int'(KW));

    // run 2: kernel resident, no reload
    push_run();
    base = wreads;
    @(negedge clk);
    reload = 1'b0;
    start = 1'b1;
    finish_run("run2", base, 0);

    // run 3: reset during kernel load word 5
    base = wreads;
    @(negedge clk);
    reload = 1'b1;
    start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (wreads - base >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_loadw_word5", 32'(hit), 32'd1);
    check("state_loadw_word5", 32'(state), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // run 4: reload=0 still loads because the reset invalidated the kernel
    push_run();
    base = wreads;
    @(negedge clk);
    reload = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("run4_enters_loadw", 32'(state), 32'd1);
    finish_run("run4", base, int'(KW));

    // ACC_W=9 instance: bias and weights +127, all inputs set
`ifdef ACC_SAT_EN
    expq.push_back(mk(1'b1, YB, 16'h0001));
`else
    expq.push_back(mk(1'b1, YB, 16'h0000));
`endif
    @(negedge clk);
    reload2 = 1'b1;
    start2 = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done2) begin
        hit = 1'b1;
        break;
      end
    end
    check("acc9_timeout", 32'(hit), 32'd1);
    check("acc9_samples_done", 32'(samples_done2), 32'd1);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    check("acc9_writes_seen", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_bin_layer.md
# dense_bin_layer

Parametrised binary-input fully-connected layer engine for the SDRAM/BRAM NN datapath. It streams the weight kernel from SDRAM into external byte-wide BRAM once. For each sample it then reads the packed 1-bit input vector, accumulates signed 8-bit weights for every set input bit plus a per-node bias, and applies a sign activation. The 1-bit outputs are packed into 16-bit words and written back to SDRAM. It supports any layer size, sample count and base address, and a kernel load that can be skipped when the weights are already resident.

## Interface
- N_IN, 360, input bits per sample (≥1)
- N_OUT, 200, output nodes per sample (≥1)
- N_SAMPLES, 100, samples per run (≥1)
- W_BASE, 32'h0, SDRAM word address of the kernel
- X_BASE, 32'hA000, SDRAM word address of sample 0 input
- Y_BASE, 32'hE000, SDRAM word address of sample 0 output
- ACC_W, 16, accumulator width (≥9)

Ports:
- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- avm_address  out  32  SDRAM word address
- avm_read_n  out  1  read request, active low
- avm_write_n  out  1  write request, active low
- avm_chipselect  out  1  constant 1
- avm_byteenable  out  2  constant 2'b11
- avm_writedata  out  16  packed output word
- avm_readdata  in  16  read data
- avm_readdatavalid  in  1  read data valid
- avm_waitrequest  in  1  slave stall
- start  in  1  run request, level
- reload  in  1  sampled with start; 1 forces kernel load
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- samples_done  out  16  completed-sample count
- wt_addr  out  17  BRAM byte address
- wt_wdata  out  8  BRAM write data
- wt_we  out  1  BRAM write enable
- wt_rdata  in  8  BRAM read data, 1-cycle latency
- state  out  4  FSM state, for debug

## Operation
- Kernel layout: node j occupies BRAM bytes j*(N_IN+1) to j*(N_IN+1)+N_IN. The first byte is the bias; weight i follows at offset i+1. All bytes are signed two's-complement.
- In SDRAM the kernel is KW=ceil(N_OUT*(N_IN+1)/2) words, low byte first.
- Inputs: WIN=ceil(N_IN/16) words per sample, starting at X_BASE+s*WIN. Input bit i is word i/16, bit i%16.
- Outputs: WOUT=ceil(N_OUT/16) words per sample, starting at Y_BASE+s*WOUT. Node j is word j/16, bit j%16. Unused upper bits are 0.
- Activation: output bit = 1 when the final accumulator is ≥0, i.e. its sign bit is clear.
- Bias and weights are sign-extended to ACC_W before adding. Default behaviour wraps modulo 2^ACC_W.
- Internal flag wt_valid: set on leaving LOADW; cleared by reset only.
- States and transitions:
  - IDLE: waits for start. On start=1 go to LOADW if reload=1 or wt_valid=0, otherwise to LOADX. samples_done is cleared on this exit.
  - LOADW: issues KW reads with avm_read_n=0, advancing the address on each cycle where avm_waitrequest=0. Each readdatavalid writes the low byte to address 2k and the high byte to 2k+1 on consecutive cycles (wt_we=1). The state exits once all KW words have been written.
  - LOADX: issues WIN reads into a shift register. It exits once WIN words have been received, then sets node j=0.
  - BIAS: presents the node j bias address.
  - ACCUM: walks i=0..N_IN-1 and adds the weight only when input bit i=1.
  - ACT: shifts the result bit into the output word.
  - WRITE: entered when j%16==15 or j==N_OUT-1; otherwise go to BIAS with j+1.
  - NEXT: increments samples_done. Goes to DONE when the sample count reaches N_SAMPLES, otherwise to LOADX for the next sample.
  - DONE: holds; returns to IDLE when start=0.
- readdatavalid beyond the expected count is ignored.
- start changes outside IDLE and DONE are ignored.

## Timing
- Reset values: avm_read_n=1, avm_write_n=1, avm_address=0, avm_writedata=0, wt_we=0, wt_addr=0, wt_wdata=0, busy=0, done=0, samples_done=0, state=IDLE. wt_valid is cleared.
- Reset asserted mid-run aborts immediately: no further BRAM writes, and in-flight read data is dropped.
- Read/write handshake: address, read_n, write_n and writedata are held stable while avm_waitrequest=1. Each is accepted on the first cycle with avm_waitrequest=0.
- Exactly one write per output word: WRITE is left on the cycle the write is accepted.
- Node compute: BIAS to ACT takes exactly N_IN+2 cycles with no stalls; there is no SDRAM access during it.
- Pipeline: a weight address presented at cycle t is summed at t+1.

## Configuration
- ACC_SAT_EN defined: every addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- ACC_SAT_EN undefined: every addition wraps.

## Test plan
- Params N_IN=20, N_OUT=18, N_SAMPLES=2, with random waitrequest:
  - Compare against a golden model -> 4 writes, at Y_BASE..Y_BASE+3.
  - Word 1 of each sample has bits 15:2 equal to 0.
  - samples_done=2 and done=1.
- All-zero input with bias=-1 -> output bit 0. All-zero input with bias=0 -> output bit 1.
- Second run with start=1 and reload=0 -> no read at W_BASE; outputs match the first run.
- reset_n pulsed low during LOADW word 5 -> all outputs take reset values that cycle.
- Restart with reload=0 -> LOADW is entered because wt_valid was cleared by the reset.
- Weights all +127, all inputs 1, ACC_W=9:
  - With ACC_SAT_EN -> accumulator 255, output 1.
  - Without -> accumulator wraps negative, output 0.
